shift_add_mult8: RTL and testbench

SHIFT_ADD_MULT8 -- requirements
Module: shift_add_mult8

---
 rtl/shift_add_mult8.sv | 116 +++++++++++
 tb/tb_shift_add_mult8.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult8.sv
// +----------------------------------------------------------------------------+
// | Module   : shift_add_mult8                                                 |
// | Function : Sequential shift-add unsigned multiplier, one bit per cycle.    |
// |            Optional macro SHIFT_ADD_MULT8_ZERO_BYPASS_EN finishes zero     |
// |            operands in a single cycle.                                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module shift_add_mult8 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplr;
  logic [WIDTH-1:0]   r_upper;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_p;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_next_upper;
  logic [WIDTH-1:0]   w_next_mplr;
  logic               w_last;
  logic               w_accept;
`ifdef SHIFT_ADD_MULT8_ZERO_BYPASS_EN
  logic               w_zero;
  assign w_zero = (a == '0) || (b == '0);
`endif

  // Carry-out of the add becomes the MSB of the combined right shift.
  assign w_sum        = {1'b0, r_upper} + (r_mplr[0] ? {1'b0, r_mcand} : '0);
  assign w_next_upper = w_sum[WIDTH:1];
  assign w_next_mplr  = {w_sum[0], r_mplr[WIDTH-1:1]};
  assign w_last       = (r_count == CW'(WIDTH - 1));
  assign w_accept     = (r_state == S_IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef SHIFT_ADD_MULT8_ZERO_BYPASS_EN
          w_state_nxt = w_zero ? S_DONE : S_BUSY;
`else
          w_state_nxt = S_BUSY;
`endif
        end
      end
      S_BUSY:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_mplr  <= '0;
      r_upper <= '0;
      r_count <= '0;
      r_p     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= a;
            r_mplr  <= b;
            r_upper <= '0;
            r_count <= '0;
`ifdef SHIFT_ADD_MULT8_ZERO_BYPASS_EN
            if (w_zero) r_p <= '0;
`endif
          end
        end
        S_BUSY: begin
          r_upper <= w_next_upper;
          r_mplr  <= w_next_mplr;
          r_count <= r_count + CW'(1);
          if (w_last) r_p <= {w_next_upper, w_next_mplr};
        end
        default: ;
      endcase
    end
  end

  assign ready = (r_state == S_IDLE);
  assign done  = (r_state == S_DONE);
  assign p     = r_p;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_mult8.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_shift_add_mult8                                              |
// | Function : Self-checking bench for shift_add_mult8 against a cycle model.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_shift_add_mult8;

  localparam int WIDTH = 8;
`ifdef SHIFT_ADD_MULT8_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a     = '0;
  logic [7:0]  b     = '0;
  logic        ready;
  logic        done;
  logic [15:0] p;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int cyc    = 0;
  int last_acc = 0;
  int prev_acc = 0;
  int acc_cnt  = 0;

  shift_add_mult8 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Abstract model: cycles remaining until the product appears, and the product itself.
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [15:0] m_p    = '0;
  logic [15:0] m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_p    = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_p    = m_pend;
      end
    end else if (start) begin
      m_pend = 16'(int'(a) * int'(b));
      if (BYPASS && (a == 0 || b == 0)) begin
        m_done = 1'b1;
        m_p    = '0;
      end else begin
        m_left = WIDTH;
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (rst_n && ready && start) begin
      prev_acc = last_acc;
      last_acc = cyc;
      acc_cnt++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("ready", int'(ready), int'(!m_done && m_left == 0));
      check("done", int'(done), int'(m_done));
      check("p", int'(p), int'(m_p));
      if (done) pulses++;
    end
  end

  // Issues one multiply and returns with the done cycle visible (#1 after an edge).
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input int exp_p, input int exp_lat);
    int n;
    n = 0;
    while (!ready && n < 50) begin @(posedge clk); #1; n++; end
    check("ready_timeout", int'(ready), 1);
    a = ta; b = tb_; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin @(posedge clk); #1; n++; end
    check("latency", n, exp_lat);
    check("product", int'(p), exp_p);
  endtask

  initial begin
    int n, p0, lat;
    logic [7:0] ra, rb;
    #8;
    check("rst_ready", int'(ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_p", int'(p), 0);
    #4 rst_n = 1'b1;

    // Start immediately after reset release, all-ones operands.
    p0 = pulses;
    run_op(8'hFF, 8'hFF, 16'hFE01, 8);
    @(posedge clk); #1;
    check("ff_ready_back", int'(ready), 1);
    check("ff_pulses", pulses - p0, 1);

    run_op(8'd1, 8'd0, 0, BYPASS ? 0 : 8);

    // Operand changes and a second start during BUSY must be ignored.
    n = 0;
    while (!ready && n < 50) begin @(posedge clk); #1; n++; end
    p0 = pulses;
    a = 8'd20; b = 8'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin @(posedge clk); #1; n++; end
    check("busy_p", int'(p), 16'h0104);
    repeat (12) begin @(posedge clk); #1; end
    check("busy_pulses", pulses - p0, 1);

    // Reset in the middle of a multiply discards it.
    a = 8'd2; b = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    p0 = pulses;
    #2 rst_n = 1'b0;
    #2;
    check("midrst_ready", int'(ready), 1);
    check("midrst_done", int'(done), 0);
    check("midrst_p", int'(p), 0);
    #1 rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    check("midrst_pulses", pulses - p0, 0);
    run_op(8'd2, 8'd3, 16'h0006, 8);

    // Back-to-back issue with start held high.
    n = 0;
    while (!ready && n < 50) begin @(posedge clk); #1; n++; end
    a = 8'h80; b = 8'h02; start = 1'b1;
    @(posedge clk); #1;
    a = 8'h0F; b = 8'h11;
    n = 0;
    while (!done && n < 20) begin @(posedge clk); #1; n++; end
    check("b2b_p1", int'(p), 16'h0100);
    n = acc_cnt;
    lat = 0;
    while (acc_cnt == n && lat < 20) begin @(posedge clk); #1; lat++; end
    start = 1'b0;
    check("b2b_interval", last_acc - prev_acc, 10);
    n = 0;
    while (!done && n < 20) begin @(posedge clk); #1; n++; end
    check("b2b_p2", int'(p), 16'h00FF);

    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i % 25 == 7) ra = 8'd0;
      lat = (BYPASS && (ra == 0 || rb == 0)) ? 0 : 8;
      run_op(ra, rb, int'(ra) * int'(rb), lat);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
